pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//   Generic pipeline-boundary register (IF/ID, ID/EX, EX/MEM, MEM/WB) with a valid/ready handshake.
//   Optional 2-entry skid buffer keeps up_ready_o registered, cutting the combinational ready path.
//   Synchronous flush kills in-flight entries on branch/trap.
//   Control bits (rf_we, dram_we, ...) read as zero on any bubble; includes transfer/stall counters.
// PARAMETERS
//   DATA_W   32  payload width (pc, alu_result, rD2, ... concatenated); never cleared on bubble
//   CTRL_W    8  control width (write enables, wd_sel, wr); forced to 0 whenever dn_valid_o=0
//   SKID      1  1: two entries, registered up_ready_o; 0: single entry, combinational up_ready_o
//   CNT_W    16  width of the performance counters
// PORTS
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous reset, active-low
//   flush_i      in   1       synchronous flush: discard all held and incoming entries
//   up_valid_i   in   1       upstream stage offers an entry
//   up_ready_o   out  1       this stage accepts the offered entry
//   up_ctrl_i    in   CTRL_W  upstream control bits
//   up_data_i    in   DATA_W  upstream payload
//   dn_valid_o   out  1       entry presented to downstream
//   dn_ready_i   in   1       downstream accepts the presented entry
//   dn_ctrl_o    out  CTRL_W  control bits; 0 when dn_valid_o=0
//   dn_data_o    out  DATA_W  payload; holds its last value when dn_valid_o=0
//   occ_o        out  2       entries held (0..2; 0..1 when SKID=0)
//   xfer_cnt_o   out  CNT_W   count of downstream handshakes (dn_valid_o && dn_ready_i); wraps mod 2^CNT_W
//   stall_cnt_o  out  CNT_W   count of cycles with dn_valid_o && !dn_ready_i; wraps mod 2^CNT_W
// BEHAVIOUR
//   Reset (rst_n=0, async)
//     - state EMPTY; dn_valid_o=0, dn_ctrl_o=0, dn_data_o=0, occ_o=0, both counters 0.
//     - up_ready_o=1 (SKID=1: registered value is 1).
//   Handshakes
//     - up_acc = up_valid_i && up_ready_o; dn_acc = dn_valid_o && dn_ready_i.
//     - Latency: EMPTY + up_acc at edge N -> dn_valid_o=1 with that entry after edge N.
//     - Strict FIFO order; no entry is dropped or duplicated except by flush.
//     - dn_ctrl_o and dn_data_o are stable while dn_valid_o && !dn_ready_i.
//   FSM, SKID=1 (main = output register, skid = overflow register)
//     - EMPTY: up_ready_o=1.
//         up_acc -> main<=up, go to BUSY.
//     - BUSY: up_ready_o=1.
//         up_acc && dn_acc -> main<=up, stay BUSY.
//         up_acc && !dn_acc -> skid<=up, go to FULL.
//         !up_acc && dn_acc -> go to EMPTY.
//     - FULL: up_ready_o=0.
//         dn_acc -> main<=skid, go to BUSY.
//     - up_ready_o is a flop output: 1 in the cycle after any edge where next state != FULL.
//   SKID=0
//     - Single entry; up_ready_o = !dn_valid_o || dn_ready_i (combinational).
//     - FULL state is unreachable.
//   Flush (highest priority, above all handshakes)
//     - At the flush edge: state<=EMPTY, both entries invalidated, dn_ctrl_o<=0.
//     - up_valid_i in the flush cycle is discarded.
//     - up_ready_o=1 in the cycle after the flush.
//     - A dn_acc in the flush cycle still counts in xfer_cnt_o.
//     - dn_data_o keeps its value.
//   Counters
//     - Not cleared by flush; cleared only by rst_n.
//     - Both may increment in the same cycle as a flush.
//   occ_o = number of valid entries after each edge.
//   Invariant: dn_valid_o=0 implies dn_ctrl_o=0 in every cycle.
// TESTING
//   T1 reset: rst_n=0 asserted mid-stream (state FULL)
//      -> same cycle: dn_valid_o=0, dn_ctrl_o=0, occ_o=0, counters=0; after release up_ready_o=1.
//   T2 streaming: dn_ready_i=1, send data 1..8, one per cycle
//      -> outputs 1..8 at 1-cycle latency, occ_o=1 throughout, xfer_cnt_o=8, stall_cnt_o=0.
//   T3 back-pressure (SKID=1): send A,B with dn_ready_i=0
//      -> occ_o=2, up_ready_o=0; raise dn_ready_i: A then B delivered; stall_cnt_o=cycles held.
//   T4 flush: state FULL holding ctrl=8'hFF; flush_i=1 with up_valid_i=1 (C)
//      -> next cycle dn_valid_o=0, dn_ctrl_o=0, occ_o=0, C never appears.
//   T5 SKID=0: dn_ready_i toggling 1,0,1,0 with continuous up_valid_i
//      -> up_ready_o tracks !dn_valid_o||dn_ready_i, FIFO order kept, no loss.
//   T6 counter wrap: CNT_W=4, 17 transfers -> xfer_cnt_o=1.

Source files
------------

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// pipe_stage_skid: valid/ready pipeline-boundary register, optional 2-entry skid buffer,
// synchronous flush, control zeroed on bubbles, transfer/stall counters.
module pipe_stage_skid #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 8,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic              up_valid_i,
   output logic              up_ready_o,
   input  logic [CTRL_W-1:0] up_ctrl_i,
   input  logic [DATA_W-1:0] up_data_i,
   output logic              dn_valid_o,
   input  logic              dn_ready_i,
   output logic [CTRL_W-1:0] dn_ctrl_o,
   output logic [DATA_W-1:0] dn_data_o,
   output logic [1:0]        occ_o,
   output logic [CNT_W-1:0]  xfer_cnt_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              state;
   logic [CTRL_W-1:0]   main_ctrl;
   logic [DATA_W-1:0]   main_data;
   logic [CTRL_W-1:0]   skid_ctrl;
   logic [DATA_W-1:0]   skid_data;
   logic                ready_q;
   logic [CNT_W-1:0]    xfer_cnt;
   logic [CNT_W-1:0]    stall_cnt;
   logic                up_acc;
   logic                dn_acc;

   assign dn_valid_o  = (state != EMPTY);
   assign dn_acc      = dn_valid_o && dn_ready_i;
   assign up_acc      = up_valid_i && up_ready_o;
   assign dn_ctrl_o   = main_ctrl;
   assign dn_data_o   = main_data;
   assign occ_o       = state;
   assign xfer_cnt_o  = xfer_cnt;
   assign stall_cnt_o = stall_cnt;

   generate
      if (SKID != 0) begin : g_skid
         assign up_ready_o = ready_q;
      end else begin : g_no_skid
         assign up_ready_o = !dn_valid_o || dn_ready_i;
      end
   endgenerate

   // main_ctrl is cleared on every transition to EMPTY, so control reads zero on bubbles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= EMPTY;
         main_ctrl <= '0;
         main_data <= '0;
         skid_ctrl <= '0;
         skid_data <= '0;
         ready_q   <= 1'b1;
         xfer_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (dn_acc)
            xfer_cnt <= xfer_cnt + CNT_W'(1);
         if (dn_valid_o && !dn_ready_i)
            stall_cnt <= stall_cnt + CNT_W'(1);

         if (flush_i) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            ready_q   <= 1'b1;
         end else begin
            case (state)
               EMPTY: begin
                  if (up_acc) begin
                     main_ctrl <= up_ctrl_i;
                     main_data <= up_data_i;
                     state     <= BUSY;
                  end
                  ready_q <= 1'b1;
               end
               BUSY: begin
                  if (up_acc && dn_acc) begin
                     main_ctrl <= up_ctrl_i;
                     main_data <= up_data_i;
                  end else if (up_acc && (SKID != 0)) begin
                     skid_ctrl <= up_ctrl_i;
                     skid_data <= up_data_i;
                     state     <= FULL;
                     ready_q   <= 1'b0;
                  end else if (dn_acc) begin
                     main_ctrl <= '0;
                     state     <= EMPTY;
                  end
               end
               FULL: begin
                  if (dn_acc) begin
                     main_ctrl <= skid_ctrl;
                     main_data <= skid_data;
                     state     <= BUSY;
                     ready_q   <= 1'b1;
                  end
               end
               default: begin
                  state     <= EMPTY;
                  main_ctrl <= '0;
                  ready_q   <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// Bench for pipe_stage_skid: SKID=1/CNT_W=16 and SKID=0/CNT_W=4 instances share stimulus,
// each checked against a queue-based reference model.
module tb_pipe_stage_skid;
   localparam int DW = 32;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          flush = 1'b0;
   logic          uv = 1'b0;
   logic          dr = 1'b0;
   logic [CW-1:0] uc = '0;
   logic [DW-1:0] ud = '0;

   logic          up_ready_a, dn_valid_a, up_ready_b, dn_valid_b;
   logic [CW-1:0] dn_ctrl_a, dn_ctrl_b;
   logic [DW-1:0] dn_data_a, dn_data_b;
   logic [1:0]    occ_a, occ_b;
   logic [15:0]   xfer_a, stall_a;
   logic [3:0]    xfer_b, stall_b;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .up_valid_i(uv), .up_ready_o(up_ready_a), .up_ctrl_i(uc), .up_data_i(ud),
      .dn_valid_o(dn_valid_a), .dn_ready_i(dr), .dn_ctrl_o(dn_ctrl_a), .dn_data_o(dn_data_a),
      .occ_o(occ_a), .xfer_cnt_o(xfer_a), .stall_cnt_o(stall_a));

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .flush_i(flush),
      .up_valid_i(uv), .up_ready_o(up_ready_b), .up_ctrl_i(uc), .up_data_i(ud),
      .dn_valid_o(dn_valid_b), .dn_ready_i(dr), .dn_ctrl_o(dn_ctrl_b), .dn_data_o(dn_data_b),
      .occ_o(occ_b), .xfer_cnt_o(xfer_b), .stall_cnt_o(stall_b));

   typedef struct packed {
      logic [CW-1:0] c;
      logic [DW-1:0] d;
   } ent_t;

   ent_t          qa[$];
   ent_t          qb[$];
   logic [DW-1:0] shown_a, shown_b;
   int            xfa, sta, xfb, stb;
   int            compared = 0;
   int            mismatched = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [CW-1:0] ec;
      logic [DW-1:0] ed;
      ec = '0;
      ed = shown_a;
      if (qa.size() > 0) begin ec = qa[0].c; ed = qa[0].d; end
      chk("a_valid", dn_valid_a, qa.size() > 0);
      chk("a_ctrl", dn_ctrl_a, ec);
      chk("a_data", dn_data_a, ed);
      chk("a_occ", occ_a, qa.size());
      chk("a_ready", up_ready_a, qa.size() < 2);
      chk("a_xfer", xfer_a, xfa & 16'hFFFF);
      chk("a_stall", stall_a, sta & 16'hFFFF);
      ec = '0;
      ed = shown_b;
      if (qb.size() > 0) begin ec = qb[0].c; ed = qb[0].d; end
      chk("b_valid", dn_valid_b, qb.size() > 0);
      chk("b_ctrl", dn_ctrl_b, ec);
      chk("b_data", dn_data_b, ed);
      chk("b_occ", occ_b, qb.size());
      chk("b_ready", up_ready_b, (qb.size() == 0) || dr);
      chk("b_xfer", xfer_b, xfb & 4'hF);
      chk("b_stall", stall_b, stb & 4'hF);
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic cycle(input logic f, input logic v, input logic [CW-1:0] c,
                        input logic [DW-1:0] d, input logic r);
      bit   acc_a, acc_b, da, db;
      ent_t e;
      flush = f; uv = v; uc = c; ud = d; dr = r;
      #1 check_all();
      acc_a = v && (qa.size() < 2);
      da    = (qa.size() > 0) && r;
      acc_b = v && ((qb.size() == 0) || r);
      db    = (qb.size() > 0) && r;
      if (da) xfa++;
      if (qa.size() > 0 && !r) sta++;
      if (db) xfb++;
      if (qb.size() > 0 && !r) stb++;
      e.c = c;
      e.d = d;
      @(posedge clk);
      if (da) void'(qa.pop_front());
      if (db) void'(qb.pop_front());
      if (f) begin
         qa.delete();
         qb.delete();
      end else begin
         if (acc_a) qa.push_back(e);
         if (acc_b) qb.push_back(e);
      end
      if (qa.size() > 0) shown_a = qa[0].d;
      if (qb.size() > 0) shown_b = qb[0].d;
      @(negedge clk);
   endtask

   // Called at a falling edge; asynchronous assert, release on a later falling edge.
   task automatic apply_reset();
      flush = 0; uv = 0; dr = 0;
      rst_n = 1'b0;
      qa.delete(); qb.delete();
      shown_a = '0; shown_b = '0;
      xfa = 0; sta = 0; xfb = 0; stb = 0;
      #1 check_all();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_ready_a", up_ready_a, 1'b1);
      chk("rst_ready_b", up_ready_b, 1'b1);
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      apply_reset();

      // streaming 1..8 at full rate
      for (int i = 1; i <= 8; i++) cycle(0, 1, CW'($urandom), DW'(i), 1);
      cycle(0, 0, '0, '0, 1);
      chk("t2_xfer", xfer_a, 16'd8);
      chk("t2_stall", stall_a, 16'd0);

      // nine more transfers: 17 total wraps the 4-bit counter to 1
      for (int i = 9; i <= 17; i++) cycle(0, 1, CW'($urandom), DW'(i), 1);
      cycle(0, 0, '0, '0, 1);
      chk("t6_wrap", xfer_b, 4'd1);

      // back-pressure fills the skid entry
      cycle(0, 1, 8'h11, 32'hAAAA_0001, 0);
      cycle(0, 1, 8'h22, 32'hBBBB_0002, 0);
      cycle(0, 0, '0, '0, 0);
      chk("t3_occ", occ_a, 2'd2);
      chk("t3_ready", up_ready_a, 1'b0);
      cycle(0, 0, '0, '0, 0);
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, 1);
      chk("t3_stall", stall_a, 16'd3);

      // flush while full with ctrl=FF, offering C in the flush cycle
      cycle(0, 1, 8'hFF, 32'hD000_0001, 0);
      cycle(0, 1, 8'hFF, 32'hD000_0002, 0);
      cycle(1, 1, 8'h5A, 32'hC0C0_C0C0, 0);
      chk("t4_valid", dn_valid_a, 1'b0);
      chk("t4_ctrl", dn_ctrl_a, 8'h00);
      chk("t4_occ", occ_a, 2'd0);
      for (int i = 0; i < 3; i++) cycle(0, 0, '0, '0, 1);

      // reset asserted mid-stream while full
      cycle(0, 1, 8'h33, 32'hE000_0001, 0);
      cycle(0, 1, 8'h44, 32'hE000_0002, 0);
      apply_reset();

      // continuous offers with downstream ready toggling
      for (int i = 0; i < 12; i++) cycle(0, 1, CW'($urandom), DW'(32'h5000 + i), (i % 2) == 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, '0, '0, 1);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         cycle(($urandom % 32) == 0, ($urandom % 4) != 0, CW'($urandom), DW'($urandom),
               ($urandom % 3) != 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
`default_nettype wire
